// File: rtl/mem_responder.sv
// Single-port memory responder: 16x32 store with per-entry written flags,
// registered read/write response and saturating write/read/miss counters.
module mem_responder #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              irst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_RESET  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_op;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]    r_wvalid;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_valid_out;
    logic [CNT_W-1:0]    r_wr_count;
    logic [CNT_W-1:0]    r_rd_count;
    logic [CNT_W-1:0]    r_miss_count;

    always_ff @(posedge clk) begin
        if (irst) r_state <= ST_RESET;
        else      r_state <= w_state_nxt;
    end

    // The first posedge leaving RESET already carries a live operation.
    always_comb begin
        w_state_nxt = r_state;
        w_op        = 1'b0;
        case (r_state)
            ST_RESET: begin
                if (!irst) begin
                    w_state_nxt = ST_ACTIVE;
                    w_op        = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (irst) w_state_nxt = ST_RESET;
                else      w_op        = 1'b1;
            end
            default: w_state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (irst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wvalid     <= '0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_wr_count   <= '0;
            r_rd_count   <= '0;
            r_miss_count <= '0;
        end else if (w_op) begin
            if (en) begin
                r_mem[addr]    <= data_in;
                r_wvalid[addr] <= 1'b1;
                r_valid_out    <= 1'b1;
                if (r_wr_count != '1) r_wr_count <= r_wr_count + CNT_W'(1);
            end else begin
                if (r_rd_count != '1) r_rd_count <= r_rd_count + CNT_W'(1);
                if (r_wvalid[addr]) begin
                    r_data_out  <= r_mem[addr];
                    r_valid_out <= 1'b1;
                end else begin
                    r_data_out  <= '0;
                    r_valid_out <= 1'b0;
                    if (r_miss_count != '1) r_miss_count <= r_miss_count + CNT_W'(1);
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign wr_count   = r_wr_count;
    assign rd_count   = r_rd_count;
    assign miss_count = r_miss_count;

endmodule
